con_unit: RTL and testbench
===========================

# con_unit

Parametrised, synchronous successor to the single CON flip-flop. It evaluates an extended 3-bit branch condition against the bus operand and writes the result into one of NPRED predicate registers. It offers the branch outcome to PC-update logic over a valid/ready handshake and keeps a saturating taken-branch counter. It sits beside the datapath bus in the control unit, driven by IR condition bits and the control sequencer.

## Interface
Parameters:
- BITS, 32, bus / operand width
- NPRED, 4, number of predicate registers (≥2, power of two)
- CNT_W, 16, taken-branch counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- bus  in  BITS  operand, two's complement
- IR_C2  in  3  condition select
- pred_sel  in  log2(NPRED)  destination predicate for an evaluation
- rd_sel  in  log2(NPRED)  predicate read select
- CON_enable  in  1  evaluation request, sampled on rising clock (level, not edge)
- flush  in  1  discard pending outcome
- taken_ready  in  1  PC logic accepts outcome
- taken_valid  out  1  outcome pending
- taken  out  1  outcome value (meaningful only while taken_valid)
- con_busy  out  1  evaluation request cannot be accepted this cycle
- Q  out  1  predicate[rd_sel]
- taken_count  out  CNT_W  saturating count of accepted taken outcomes

## Operation
- Condition encoding (C = result):
  - 000 bus==0
  - 001 bus!=0
  - 010 MSB==0
  - 011 MSB==1
  - 100 bus!=0 and MSB==0 (>0)
  - 101 bus==0 or MSB==1 (≤0)
  - 110 always 1
  - 111 always 0
- FSM states:
  - IDLE: no outcome pending.
  - HOLD: taken_valid=1, outcome waiting for the handshake.
- Accept condition: accept = CON_enable & ~flush & (state==IDLE | taken_ready).
- On accept:
  - predicate[pred_sel] <= C
  - taken <= C
  - state <= HOLD
- HOLD & taken_ready & ~accept → IDLE.
- HOLD & taken_ready & accept → HOLD with new outcome (back-to-back, no bubble).
- HOLD & ~taken_ready: state, taken and all predicates hold. con_busy = 1, and CON_enable is ignored (upstream must hold the request).
- con_busy = (state==HOLD) & ~taken_ready; it is combinational.
- flush:
  - Forces IDLE next cycle and drops any pending outcome.
  - Overrides a simultaneous CON_enable: no predicate write, no count.
  - Predicates are untouched.
- taken_count increments when taken_valid & taken_ready & taken & ~flush. It saturates at all-ones and does not wrap.
- Q is a combinational read of the predicate registers. On a same-cycle write to rd_sel, Q shows the old value; the new value appears after the edge.

## Timing
- Reset (synchronous, dominates everything):
  - state IDLE
  - all predicates 0
  - taken 0, taken_valid 0
  - taken_count 0
  - con_busy 0, Q 0
- Latency: request accepted at edge k → taken_valid=1, taken, and updated predicate visible after edge k.
- Throughput: one evaluation per cycle while taken_ready stays high.
- Handshake: taken_valid stays high, with taken stable, until the cycle taken_ready=1 is sampled.
- Reset or flush asserted in HOLD clears taken_valid after that edge. Reset also zeroes the counter; flush does not.
- taken_ready in IDLE has no effect.

## Structure
- Package con_pkg holds:
  - condition code localparams (COND_ZERO … COND_NEVER)
  - FSM state encoding (IDLE, HOLD)
- Sub-module con_eval: purely combinational; inputs bus and IR_C2, output C; parameter BITS.
- con_unit contains the predicate register array, FSM, outcome register and saturating counter.

## Test plan
- Reset, then IR_C2=000, bus=0, pred_sel=2, CON_enable one cycle, taken_ready=1 → taken_valid=1 and taken=1 one cycle later; Q=1 with rd_sel=2; taken_count=1.
- Sweep all 8 codes with bus ∈ {0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF} → C matches the encoding list (e.g. 100 with 0x80000000 → 0; 101 with 0 → 1).
- taken_ready held low 3 cycles after an evaluation → taken_valid and taken stable, con_busy=1, a second CON_enable is ignored, and predicates are unchanged. Raise ready together with a new request → back-to-back outcome with no idle cycle.
- flush asserted together with CON_enable in HOLD → IDLE next cycle, taken_valid=0, target predicate and taken_count unchanged.
- With CNT_W=4, accept 17 taken outcomes → taken_count holds at 15. Then assert reset mid-HOLD → all outputs 0 after the edge.

Source files
------------

// File: rtl/con_pkg.sv
// Shared definitions for the condition/predicate unit: condition codes and FSM states.
package con_pkg;

  localparam logic [2:0] COND_ZERO   = 3'b000;
  localparam logic [2:0] COND_NZERO  = 3'b001;
  localparam logic [2:0] COND_NNEG   = 3'b010;
  localparam logic [2:0] COND_NEG    = 3'b011;
  localparam logic [2:0] COND_GT0    = 3'b100;
  localparam logic [2:0] COND_LE0    = 3'b101;
  localparam logic [2:0] COND_ALWAYS = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/con_if.sv
// Bus-side signal bundle of con_unit: operand, condition select, predicate selects and outcome handshake.
interface con_if #(
  parameter int BITS  = 32,
  parameter int NPRED = 4,
  parameter int CNT_W = 16
);
  localparam int PW = $clog2(NPRED);

  logic [BITS-1:0]  bus;
  logic [2:0]       IR_C2;
  logic [PW-1:0]    pred_sel;
  logic [PW-1:0]    rd_sel;
  logic             CON_enable;
  logic             flush;
  logic             taken_ready;
  logic             taken_valid;
  logic             taken;
  logic             con_busy;
  logic             Q;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output bus, IR_C2, pred_sel, rd_sel, CON_enable, flush, taken_ready,
    input  taken_valid, taken, con_busy, Q, taken_count
  );

  modport slave (
    input  bus, IR_C2, pred_sel, rd_sel, CON_enable, flush, taken_ready,
    output taken_valid, taken, con_busy, Q, taken_count
  );
endinterface

// File: rtl/con_eval.sv
// Combinational branch-condition evaluator: operand sign/zero tests selected by a 3-bit code.
module con_eval
  import con_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] bus,
  input  logic [2:0]      IR_C2,
  output logic            C
);
  logic zero;
  logic neg;

  assign zero = (bus == '0);
  assign neg  = bus[BITS-1];

  always_comb begin
    C = 1'b0;
    unique case (IR_C2)
      COND_ZERO:   C = zero;
      COND_NZERO:  C = ~zero;
      COND_NNEG:   C = ~neg;
      COND_NEG:    C = neg;
      COND_GT0:    C = ~zero & ~neg;
      COND_LE0:    C = zero | neg;
      COND_ALWAYS: C = 1'b1;
      COND_NEVER:  C = 1'b0;
      default:     C = 1'b0;
    endcase
  end
endmodule

// File: rtl/con_unit.sv
// Predicate register file with a valid/ready branch-outcome port and saturating taken counter.
module con_unit
  import con_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int NPRED = 4,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  con_if.slave cif
);
  state_t           state_q, state_d;
  logic             taken_q, taken_d;
  logic [NPRED-1:0] pred_q, pred_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c;
  logic             accept;
  logic             count_inc;

  con_eval #(.BITS(BITS)) u_eval (
    .bus   (cif.bus),
    .IR_C2 (cif.IR_C2),
    .C     (c)
  );

  // A new request may replace the pending outcome in the same cycle it is consumed.
  assign accept    = cif.CON_enable & ~cif.flush & ((state_q == IDLE) | cif.taken_ready);
  assign count_inc = (state_q == HOLD) & cif.taken_ready & taken_q & ~cif.flush;

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;

    if (count_inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    if (cif.flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d              = HOLD;
      taken_d              = c;
      pred_d[cif.pred_sel] = c;
    end else if ((state_q == HOLD) && cif.taken_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      pred_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cif.taken_valid = (state_q == HOLD);
  assign cif.taken       = taken_q;
  assign cif.con_busy    = (state_q == HOLD) & ~cif.taken_ready;
  assign cif.Q           = pred_q[cif.rd_sel];
  assign cif.taken_count = cnt_q;
endmodule

// File: tb/tb_con_unit.sv
// Directed + randomized bench for con_unit against a transaction-level reference model.
module tb_con_unit;
  localparam int BITS  = 32;
  localparam int NPRED = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  con_if #(.BITS(BITS), .NPRED(NPRED), .CNT_W(CNT_W)) bif ();

  con_unit #(.BITS(BITS), .NPRED(NPRED), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .cif   (bif.slave)
  );

  int tests = 0;
  int fails = 0;

  // reference model: pending outcome, predicate values, count
  bit m_valid;
  bit m_taken;
  bit m_pred [NPRED];
  int m_cnt;

  function automatic bit ref_cond(logic [2:0] code, logic [31:0] b);
    int s;
    s = b;
    case (code)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s >= 0;
      3'd3: return s < 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_taken = 0;
    m_cnt   = 0;
    for (int i = 0; i < NPRED; i++) m_pred[i] = 0;
  endtask

  // one clock: check combinational outputs, advance model across the edge, check registered outputs
  task automatic step();
    bit acc, inc, c;
    #1;
    chk("con_busy", bif.con_busy, m_valid & ~bif.taken_ready);
    chk("q_pre", bif.Q, m_pred[bif.rd_sel]);
    c   = ref_cond(bif.IR_C2, bif.bus);
    acc = bif.CON_enable & ~bif.flush & (~m_valid | bif.taken_ready);
    inc = m_valid & bif.taken_ready & m_taken & ~bif.flush;
    @(posedge clock);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (inc && m_cnt < MAXC) m_cnt++;
      if (acc) begin
        m_pred[bif.pred_sel] = c;
        m_taken = c;
        m_valid = 1;
      end else if (bif.flush || bif.taken_ready) begin
        m_valid = 0;
      end
    end
    chk("taken_valid", bif.taken_valid, m_valid);
    if (m_valid || reset) chk("taken", bif.taken, m_taken);
    chk("taken_count", bif.taken_count, m_cnt);
    chk("q_post", bif.Q, m_pred[bif.rd_sel]);
  endtask

  task automatic drive(bit en, bit rdy, bit fl, logic [2:0] code, logic [31:0] b,
                       logic [1:0] ps, logic [1:0] rs);
    bif.CON_enable  = en;
    bif.taken_ready = rdy;
    bif.flush       = fl;
    bif.IR_C2       = code;
    bif.bus         = b;
    bif.pred_sel    = ps;
    bif.rd_sel      = rs;
  endtask

  logic [31:0] bvals [5];

  initial begin
    bvals[0] = 32'h0000_0000;
    bvals[1] = 32'h0000_0001;
    bvals[2] = 32'h7FFF_FFFF;
    bvals[3] = 32'h8000_0000;
    bvals[4] = 32'hFFFF_FFFF;

    reset = 1'b1;
    drive(0, 0, 0, 3'd0, 32'd0, 2'd0, 2'd0);
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    chk("rst_valid", bif.taken_valid, 0);
    chk("rst_taken", bif.taken, 0);
    chk("rst_count", bif.taken_count, 0);
    chk("rst_busy", bif.con_busy, 0);
    chk("rst_q", bif.Q, 0);
    reset = 1'b0;

    // first evaluation: zero test on bus=0 into predicate 2
    drive(1, 1, 0, 3'd0, 32'd0, 2'd2, 2'd2);
    step();
    chk("first_taken", bif.taken, 1);
    chk("first_q", bif.Q, 1);
    drive(0, 1, 0, 3'd0, 32'd0, 2'd2, 2'd2);
    step();
    chk("first_count", bif.taken_count, 1);

    // all codes against boundary operands, back-to-back
    for (int code = 0; code < 8; code++)
      for (int k = 0; k < 5; k++) begin
        drive(1, 1, 0, code[2:0], bvals[k], 2'(k), 2'(k));
        step();
      end
    drive(0, 1, 0, 3'd0, 32'd0, 2'd0, 2'd0);
    step();

    // stall: outcome held while ready low, extra requests ignored
    drive(1, 0, 0, 3'd6, 32'd5, 2'd1, 2'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 3'd7, 32'd0, 2'd3, 2'd3);
      step();
      chk("stall_busy", bif.con_busy, 1);
    end
    drive(1, 1, 0, 3'd5, 32'd0, 2'd0, 2'd0);
    step();
    chk("b2b_valid", bif.taken_valid, 1);

    // flush with a simultaneous request while holding
    drive(1, 0, 0, 3'd4, 32'd9, 2'd1, 2'd1);
    step();
    drive(1, 1, 1, 3'd7, 32'd0, 2'd1, 2'd1);
    step();
    chk("flush_valid", bif.taken_valid, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
            3'($urandom), ($urandom_range(0, 3) == 0) ? bvals[$urandom_range(0, 4)] : $urandom,
            2'($urandom), 2'($urandom));
      step();
    end

    // saturation from a clean start
    reset = 1'b1;
    drive(0, 0, 0, 3'd0, 32'd0, 2'd0, 2'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 3'd6, $urandom, 2'($urandom), 2'($urandom));
      step();
    end
    drive(0, 1, 0, 3'd0, 32'd0, 2'd0, 2'd0);
    step();
    chk("sat_count", bif.taken_count, MAXC);

    // reset while an outcome is pending
    drive(1, 0, 0, 3'd6, 32'd0, 2'd3, 2'd3);
    step();
    drive(1, 0, 0, 3'd6, 32'd0, 2'd3, 2'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_hold_valid", bif.taken_valid, 0);
    chk("rst_hold_count", bif.taken_count, 0);
    chk("rst_hold_q", bif.Q, 0);
    drive(0, 0, 0, 3'd0, 32'd0, 2'd0, 2'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
